fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch control for the 5-stage RV32I pipeline. Owns the PC and drives the word address
//   into the combinational instruction memory. Captures the returned word into the IF/ID pipeline
//   register for decode. Handles stall, flush, branch/jump redirect from EX, and a halt request.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   NOP_INSTR  32'h0000_0013  bubble encoding (ADDI x0,x0,0) written into IF/ID on flush/redirect
// PORTS
//   clk              in   1   rising-edge clock
//   rst              in   1   asynchronous, active-high reset
//   imem_addr        out  32  byte address to instruction memory; = pc, combinational
//   imem_rdata       in   32  instruction word from memory, valid in the same cycle as imem_addr
//   stall            in   1   hazard unit: hold PC and IF/ID
//   flush            in   1   replace the IF/ID contents with a bubble
//   redirect_valid   in   1   EX resolved a taken branch/jump
//   redirect_target  in   32  new PC; bits [1:0] ignored (forced 0)
//   halt_req         in   1   stop fetching (ECALL/EBREAK retire)
//   if_id_valid      out  1   IF/ID holds a real instruction
//   if_id_pc         out  32  PC of the IF/ID instruction
//   if_id_pc4        out  32  if_id_pc + 4
//   if_id_instr      out  32  instruction word, or NOP_INSTR when the register holds a bubble
//   fetch_count      out  32  instructions delivered to decode (valid IF/ID loads)
//   halted           out  1   FSM is in HALT
// BEHAVIOUR
//   Reset (async, any cycle, including mid-stall or mid-redirect) forces these values:
//     pc = RESET_PC, state = BOOT, if_id_valid = 0, if_id_pc = 0, if_id_pc4 = 0,
//     if_id_instr = NOP_INSTR, fetch_count = 0, halted = 0.
//   FSM:
//     BOOT: one cycle after rst deasserts. No IF/ID load; pc holds. Always goes to RUN.
//       This covers the cycle in which memory may still present 0.
//     RUN: normal fetch. Goes to HALT when halt_req=1 and redirect_valid=0.
//     HALT: pc holds. Each cycle loads a bubble (valid = 0). Leaves only on redirect_valid
//       (go to RUN at the target) or on reset.
//   Per-clock priority in RUN: redirect > stall > flush > normal.
//     redirect_valid: pc <= {target[31:2],2'b00}; IF/ID <= bubble. Overrides stall and flush.
//     stall (no redirect): pc and all IF/ID fields hold; fetch_count holds.
//     flush (no stall): IF/ID <= bubble; pc <= pc+4.
//     normal: IF/ID <= {valid=1, pc, pc+4, imem_rdata}; pc <= pc+4; fetch_count += 1.
//   Bubble means valid=0 and instr=NOP_INSTR. The pc/pc4 fields of a bubble are don't-care
//   (implementation writes the current pc).
//   Latency: the instruction at address A appears on if_id_* on the clock edge after imem_addr=A.
//   Arithmetic: all 32-bit and modulo 2^32. PC 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
//     pc4 wraps the same way. fetch_count wraps from 0xFFFF_FFFF to 0.
//   pc[1:0] is always 00. A misaligned redirect is silently aligned; there is no trap in this stage.
//   halt_req and stall in the same cycle: HALT is entered and the IF/ID contents hold for that edge.
// STRUCTURE
//   fetch_pkg: fetch_state_t enum {BOOT,RUN,HALT}, NOP_INSTR constant, RESET_PC default.
//   Sub-module if_id_reg: pipeline register with load/hold/bubble controls and async reset.
//   fetch_stage keeps the PC, the FSM, the next-PC mux and the counter.
// TESTING
//   1 Reset then release with memory preloaded at words 0..3 -> BOOT holds 1 cycle.
//     Then if_id_pc = 0,4,8,C on successive edges, instr matches memory, fetch_count = 1,2,3,4.
//   2 stall held 3 cycles at pc=8 -> imem_addr stays 8; if_id_* and fetch_count unchanged.
//     After release, the next edge loads pc=8.
//   3 redirect_valid with target 0x0000_0042 while stall=1 and flush=1 -> next pc = 0x40.
//     IF/ID holds a bubble (valid=0, instr=0x00000013); the following edge delivers pc=0x40.
//   4 flush alone at pc=0x10 -> IF/ID is a bubble; next pc = 0x14; fetch_count not incremented.
//   5 halt_req at pc=0x1C -> halted=1 and pc holds at 0x1C with valid=0 each cycle.
//     redirect to 0x0 -> RUN, pc = 0.
//   6 Force pc to 0xFFFF_FFFC, normal fetch -> if_id_pc4 = 0, next pc = 0.
//     Assert rst mid-stream -> all outputs immediately take their reset values, with no clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the instruction-fetch stage.
//   fetch_state_t  : fetch FSM state (BOOT, RUN, HALT)
//   DEFAULT_NOP_INSTR / DEFAULT_RESET_PC : default parameter values
//   align_word()   : clears the two low address bits of a byte address
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // ADDI x0,x0,0 -- the canonical bubble
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

    // Instruction addresses are always word aligned; misaligned targets are silently fixed.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register with load / bubble / hold controls.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     load              : capture {valid=1, in_pc, in_pc+4, in_instr}
//     bubble            : capture {valid=0, in_pc, in_pc+4, NOP_INSTR}
//     in_pc, in_instr   : PC and instruction word being captured
//     valid, pc, pc4, instr : registered IF/ID contents
//   When neither load nor bubble is set the register holds.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr
);

    // Bubble takes priority over load so a redirect can never leak a real instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= 32'h0000_0000;
            pc4   <= 32'h0000_0000;
            instr <= NOP_INSTR;
        end else if (bubble) begin
            valid <= 1'b0;
            pc    <= in_pc;
            pc4   <= in_pc + 32'd4;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= in_pc;
            pc4   <= in_pc + 32'd4;
            instr <= in_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch control for the 5-stage RV32I pipeline. Owns the PC, drives the
//   combinational instruction memory and fills the IF/ID register.
//   Ports:
//     clk, rst                        : clock, asynchronous active-high reset
//     imem_addr / imem_rdata          : instruction memory address (= pc) and returned word
//     stall, flush                    : hazard-unit hold and bubble requests
//     redirect_valid, redirect_target : taken branch/jump from EX
//     halt_req                        : stop fetching
//     if_id_valid/pc/pc4/instr        : IF/ID register contents
//     fetch_count                     : number of real instructions delivered to decode
//     halted                          : FSM is in HALT
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic [31:0] fetch_count,
    output logic        halted
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic         ifid_load, ifid_bubble, count_inc;

    assign imem_addr = pc;

    // Next-state / next-PC decision. Within RUN a redirect wins over everything, then a halt
    // request, then stall, flush and finally a normal fetch. A halt that coincides with a
    // stall leaves IF/ID untouched; otherwise the halt edge already writes a bubble.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        count_inc   = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_next     = align_word(redirect_target);
                    ifid_bubble = 1'b1;
                end else if (halt_req) begin
                    state_next  = HALT;
                    ifid_bubble = !stall;
                end else if (stall) begin
                    pc_next = pc;
                end else if (flush) begin
                    pc_next     = pc + 32'd4;
                    ifid_bubble = 1'b1;
                end else begin
                    pc_next   = pc + 32'd4;
                    ifid_load = 1'b1;
                    count_inc = 1'b1;
                end
            end
            HALT: begin
                ifid_bubble = 1'b1;
                if (redirect_valid) begin
                    pc_next    = align_word(redirect_target);
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // FSM state, PC, delivered-instruction counter and the registered halted flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_count <= 32'h0000_0000;
            halted      <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            halted <= (state_next == HALT);
            if (count_inc) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .in_pc    (pc),
        .in_instr (imem_rdata),
        .valid    (if_id_valid),
        .pc       (if_id_pc),
        .pc4      (if_id_pc4),
        .instr    (if_id_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed self-checking bench for fetch_stage. Instruction memory holds
//   32'h1000_0000 + word_index for addresses below 0x80 and ~addr elsewhere.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic [31:0] fetch_count;
    logic        halted;

    logic [31:0] mem [0:31];
    int          n_cmp;
    int          n_fail;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_pc4       (if_id_pc4),
        .if_id_instr     (if_id_instr),
        .fetch_count     (fetch_count),
        .halted          (halted)
    );

    // Free-running clock, first rising edge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational instruction memory model.
    always_comb begin
        if (imem_addr < 32'h0000_0080) imem_rdata = mem[imem_addr[6:2]];
        else                           imem_rdata = ~imem_addr;
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; halt_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2;
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_addr got %h want %h", imem_addr, 32'h0); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid got %b want 0", if_id_valid); end
        n_cmp++; if (if_id_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_pc got %h want 0", if_id_pc); end
        n_cmp++; if (if_id_pc4 !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_pc4 got %h want 0", if_id_pc4); end
        n_cmp++; if (if_id_instr !== 32'h0000_0013) begin n_fail++; $display("[TB] FAIL rst_instr got %h want 00000013", if_id_instr); end
        n_cmp++; if (fetch_count !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_count got %h want 0", fetch_count); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_halted got %b want 0", halted); end
        step();
        rst = 1'b0;
        step();
        n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_valid got %b want 0", if_id_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL boot_addr got %h want 0", imem_addr); end
        n_cmp++; if (fetch_count !== 32'h0) begin n_fail++; $display("[TB] FAIL boot_count got %h want 0", fetch_count); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [0:3];
        logic [31:0] exp_in [0:3];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_in = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003};
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (if_id_pc !== exp_pc[i]) begin n_fail++; $display("[TB] FAIL seq_pc[%0d] got %h want %h", i, if_id_pc, exp_pc[i]); end
            n_cmp++; if (if_id_instr !== exp_in[i]) begin n_fail++; $display("[TB] FAIL seq_instr[%0d] got %h want %h", i, if_id_instr, exp_in[i]); end
            n_cmp++; if (fetch_count !== 32'(i + 1)) begin n_fail++; $display("[TB] FAIL seq_count[%0d] got %0d want %0d", i, fetch_count, i + 1); end
            n_cmp++; if (if_id_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_valid[%0d] got %b want 1", i, if_id_valid); end
        end
        n_cmp++; if (if_id_pc4 !== 32'h10) begin n_fail++; $display("[TB] FAIL seq_pc4 got %h want 00000010", if_id_pc4); end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("[TB] FAIL stall_addr[%0d] got %h want 00000008", i, imem_addr); end
            n_cmp++; if (if_id_pc !== 32'h4) begin n_fail++; $display("[TB] FAIL stall_pc[%0d] got %h want 00000004", i, if_id_pc); end
            n_cmp++; if (fetch_count !== 32'd2) begin n_fail++; $display("[TB] FAIL stall_count[%0d] got %0d want 2", i, fetch_count); end
        end
        stall = 1'b0;
        step();
        n_cmp++; if (if_id_pc !== 32'h8) begin n_fail++; $display("[TB] FAIL unstall_pc got %h want 00000008", if_id_pc); end
        n_cmp++; if (if_id_instr !== 32'h1000_0002) begin n_fail++; $display("[TB] FAIL unstall_instr got %h want 10000002", if_id_instr); end
        n_cmp++; if (fetch_count !== 32'd3) begin n_fail++; $display("[TB] FAIL unstall_count got %0d want 3", fetch_count); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0042; stall = 1'b1; flush = 1'b1;
        step();
        clear_inputs();
        n_cmp++; if (imem_addr !== 32'h40) begin n_fail++; $display("[TB] FAIL redir_addr got %h want 00000040", imem_addr); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_valid got %b want 0", if_id_valid); end
        n_cmp++; if (if_id_instr !== 32'h0000_0013) begin n_fail++; $display("[TB] FAIL redir_instr got %h want 00000013", if_id_instr); end
        n_cmp++; if (fetch_count !== 32'd3) begin n_fail++; $display("[TB] FAIL redir_count got %0d want 3", fetch_count); end
        step();
        n_cmp++; if (if_id_pc !== 32'h40) begin n_fail++; $display("[TB] FAIL redir_pc got %h want 00000040", if_id_pc); end
        n_cmp++; if (if_id_instr !== 32'h1000_0010) begin n_fail++; $display("[TB] FAIL redir_fetch got %h want 10000010", if_id_instr); end
        n_cmp++; if (fetch_count !== 32'd4) begin n_fail++; $display("[TB] FAIL redir_count2 got %0d want 4", fetch_count); end
    endtask

    task automatic test_flush();
        redirect_valid = 1'b1; redirect_target = 32'h0000_0010;
        step();
        clear_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid got %b want 0", if_id_valid); end
        n_cmp++; if (if_id_instr !== 32'h0000_0013) begin n_fail++; $display("[TB] FAIL flush_instr got %h want 00000013", if_id_instr); end
        n_cmp++; if (imem_addr !== 32'h14) begin n_fail++; $display("[TB] FAIL flush_addr got %h want 00000014", imem_addr); end
        n_cmp++; if (fetch_count !== 32'd4) begin n_fail++; $display("[TB] FAIL flush_count got %0d want 4", fetch_count); end
        step();
        n_cmp++; if (if_id_pc !== 32'h14) begin n_fail++; $display("[TB] FAIL postflush_pc got %h want 00000014", if_id_pc); end
        n_cmp++; if (fetch_count !== 32'd5) begin n_fail++; $display("[TB] FAIL postflush_count got %0d want 5", fetch_count); end
    endtask

    task automatic test_halt();
        step();
        n_cmp++; if (imem_addr !== 32'h1C) begin n_fail++; $display("[TB] FAIL prehalt_addr got %h want 0000001c", imem_addr); end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_flag[%0d] got %b want 1", i, halted); end
            n_cmp++; if (imem_addr !== 32'h1C) begin n_fail++; $display("[TB] FAIL halt_addr[%0d] got %h want 0000001c", i, imem_addr); end
            n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_valid[%0d] got %b want 0", i, if_id_valid); end
            step();
        end
        n_cmp++; if (fetch_count !== 32'd6) begin n_fail++; $display("[TB] FAIL halt_count got %0d want 6", fetch_count); end
        redirect_valid = 1'b1; redirect_target = 32'h0;
        step();
        clear_inputs();
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL unhalt_flag got %b want 0", halted); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL unhalt_addr got %h want 0", imem_addr); end
        step();
        n_cmp++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL unhalt_fetch got pc=%h v=%b want pc=0 v=1", if_id_pc, if_id_valid); end
        n_cmp++; if (fetch_count !== 32'd7) begin n_fail++; $display("[TB] FAIL unhalt_count got %0d want 7", fetch_count); end
    endtask

    task automatic test_halt_stall();
        halt_req = 1'b1; stall = 1'b1;
        step();
        clear_inputs();
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("[TB] FAIL hs_flag got %b want 1", halted); end
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL hs_hold got v=%b pc=%h want v=1 pc=0", if_id_valid, if_id_pc); end
        n_cmp++; if (imem_addr !== 32'h4) begin n_fail++; $display("[TB] FAIL hs_addr got %h want 00000004", imem_addr); end
        step();
        n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL hs_bubble got %b want 0", if_id_valid); end
    endtask

    task automatic test_wrap_and_async_reset();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_addr got %h want fffffffc", imem_addr); end
        step();
        n_cmp++; if (if_id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_pc got %h want fffffffc", if_id_pc); end
        n_cmp++; if (if_id_pc4 !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_pc4 got %h want 0", if_id_pc4); end
        n_cmp++; if (if_id_instr !== 32'h0000_0003) begin n_fail++; $display("[TB] FAIL wrap_instr got %h want 00000003", if_id_instr); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_next got %h want 0", imem_addr); end
        n_cmp++; if (fetch_count !== 32'd8) begin n_fail++; $display("[TB] FAIL wrap_count got %0d want 8", fetch_count); end
        step();
        n_cmp++; if (fetch_count !== 32'd9 || imem_addr !== 32'h4) begin n_fail++; $display("[TB] FAIL pre_rst got cnt=%0d addr=%h want cnt=9 addr=4", fetch_count, imem_addr); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL async_addr got %h want 0", imem_addr); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_valid got %b want 0", if_id_valid); end
        n_cmp++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin n_fail++; $display("[TB] FAIL async_pc got %h/%h want 0/0", if_id_pc, if_id_pc4); end
        n_cmp++; if (if_id_instr !== 32'h0000_0013) begin n_fail++; $display("[TB] FAIL async_instr got %h want 00000013", if_id_instr); end
        n_cmp++; if (fetch_count !== 32'h0) begin n_fail++; $display("[TB] FAIL async_count got %0d want 0", fetch_count); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL async_halted got %b want 0", halted); end
        step();
        rst = 1'b0;
    endtask

    // Scenario sequence; each task continues from the state the previous one left.
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush();
        test_halt();
        test_halt_stall();
        test_wrap_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
